// File: rtl/valid_pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// valid_pipeline_ctrl_pkg
// Shared definitions for the load-phase responder and the top-level sequencer:
//   - sequencer mode encodings (MODE_IDLE / MODE_LOAD / MODE_LAYER)
//   - responder FSM state encoding (state_t)
// No ports; imported by valid_pipeline_ctrl and valid_skew_gen.
// -----------------------------------------------------------------------------
package valid_pipeline_ctrl_pkg;

    // Sequencer mode encodings, shared with the sequencer.
    localparam logic [2:0] MODE_IDLE  = 3'd0;
    localparam logic [2:0] MODE_LOAD  = 3'd1;
    localparam logic [2:0] MODE_LAYER = 3'd2;

    // Responder FSM states. Encodings 5..7 are illegal and recover to S_IDLE.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage : valid_pipeline_ctrl_pkg

// File: rtl/valid_pipeline_ctrl_skew_gen.sv
// -----------------------------------------------------------------------------
// valid_skew_gen
// Combinational row-skewed valid generator for the systolic array input edge.
// Row r is valid while the stream is active and r <= t < r + LOAD_LEN.
// Ports:
//   active_i  in  1      stream phase active
//   t_i       in  CNT_W  local stream time
//   valid_o   out ROWS   per-row input valid
// -----------------------------------------------------------------------------
module valid_skew_gen
    import valid_pipeline_ctrl_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int LOAD_LEN = 4,
    parameter int CNT_W    = 8
) (
    input  logic             active_i,
    input  logic [CNT_W-1:0] t_i,
    output logic [ROWS-1:0]  valid_o
);

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LOAD_LEN);

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        localparam logic [CNT_W-1:0] OFFS_C = CNT_W'(gi);
        logic [CNT_W-1:0] rel;

        // Single unsigned compare covers both bounds: when t < gi the
        // subtraction wraps to a value far above LOAD_LEN, because the
        // counter width holds LOAD_LEN+ROWS-1.
        assign rel          = t_i - OFFS_C;
        assign valid_o[gi]  = active_i && (rel < LEN_C);
    end

endmodule : valid_skew_gen

// File: rtl/valid_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// valid_pipeline_ctrl
// Responder side of the load-phase start/busy handshake. An accepted start
// (start && mode == MODE_LOAD while idle) runs three phases back to back:
// weight shift-in (ROWS cycles), skewed input streaming (LOAD_LEN+ROWS-1
// cycles) and array drain (COLS cycles), then pulses done for one cycle.
// Ports:
//   clk         in  1      system clock
//   rst         in  1      asynchronous active-high reset
//   mode        in  3      sequencer mode
//   start       in  1      one-cycle start pulse
//   busy        out 1      high for the whole run
//   w_shift_en  out 1      weight chain shift enable
//   w_latch     out 1      weight commit pulse (first stream cycle)
//   in_valid    out ROWS   per-row skewed input valid
//   rd_addr     out CNT_W  row-0 input buffer read address
//   done        out 1      one-cycle pulse after busy falls
// All outputs are registered and decoded from the next state so that they
// line up with the state they describe.
// -----------------------------------------------------------------------------
module valid_pipeline_ctrl
    import valid_pipeline_ctrl_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int LOAD_LEN = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic             start,
    output logic             busy,
    output logic             w_shift_en,
    output logic             w_latch,
    output logic [ROWS-1:0]  in_valid,
    output logic [CNT_W-1:0] rd_addr,
    output logic             done
);

    localparam int STREAM_LEN = LOAD_LEN + ROWS - 1;

    localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(STREAM_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(COLS - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST   = CNT_W'(LOAD_LEN - 1);
    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             busy_q, busy_d;
    logic             w_shift_en_q, w_shift_en_d;
    logic             w_latch_q, w_latch_d;
    logic [ROWS-1:0]  in_valid_q, in_valid_d;
    logic [CNT_W-1:0] rd_addr_q, rd_addr_d;
    logic             done_q, done_d;
    logic             stream_d;

    // ---------------------------------------------------------------------
    // Next-state and phase counter
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = S_IDLE;
        cnt_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (start && (mode == MODE_LOAD)) begin
                    state_d = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d = S_STREAM;
                end else begin
                    state_d = S_LOAD_W;
                    cnt_d   = cnt_q + ONE_C;
                end
            end
            S_STREAM: begin
                if (cnt_q == STREAM_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_STREAM;
                    cnt_d   = cnt_q + ONE_C;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                    cnt_d   = cnt_q + ONE_C;
                end
            end
            S_DONE: begin
                // Start is not looked at here; accepts resume from S_IDLE.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Output decode from the next state (registered below)
    // ---------------------------------------------------------------------
    assign stream_d = (state_d == S_STREAM);

    valid_skew_gen #(
        .ROWS     (ROWS),
        .LOAD_LEN (LOAD_LEN),
        .CNT_W    (CNT_W)
    ) u_skew (
        .active_i (stream_d),
        .t_i      (cnt_d),
        .valid_o  (in_valid_d)
    );

    always_comb begin
        busy_d       = (state_d == S_LOAD_W) || (state_d == S_STREAM) ||
                       (state_d == S_DRAIN);
        w_shift_en_d = (state_d == S_LOAD_W);
        w_latch_d    = stream_d && (cnt_d == '0);
        done_d       = (state_d == S_DONE);
        rd_addr_d    = '0;
        if (stream_d) begin
            // Row 0 walks the buffer, then parks on the last vector while
            // the lower rows finish their skewed tail.
            rd_addr_d = (cnt_d > ADDR_LAST) ? ADDR_LAST : cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            w_shift_en_q <= 1'b0;
            w_latch_q    <= 1'b0;
            in_valid_q   <= '0;
            rd_addr_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            w_shift_en_q <= w_shift_en_d;
            w_latch_q    <= w_latch_d;
            in_valid_q   <= in_valid_d;
            rd_addr_q    <= rd_addr_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign w_shift_en = w_shift_en_q;
    assign w_latch    = w_latch_q;
    assign in_valid   = in_valid_q;
    assign rd_addr    = rd_addr_q;
    assign done       = done_q;

endmodule : valid_pipeline_ctrl

// File: tb/tb_valid_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_valid_pipeline_ctrl
// Scoreboard bench: stimulus pushes per-cycle expected output vectors into a
// queue per DUT; a negedge monitor pops and compares them against the DUT.
// dut0 uses default parameters, dut1 uses ROWS=2, LOAD_LEN=1, COLS=1.
// Expected vector layout: {busy, w_shift_en, w_latch, in_valid[3:0],
// rd_addr[7:0], done}.
// -----------------------------------------------------------------------------
module tb_valid_pipeline_ctrl;
    import valid_pipeline_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mode0 = 3'd0, mode1 = 3'd0;
    logic       start0 = 1'b0, start1 = 1'b0;

    logic       busy0, wsh0, wl0, done0;
    logic [3:0] iv0;
    logic [7:0] ra0;
    logic       busy1, wsh1, wl1, done1;
    logic [1:0] iv1;
    logic [7:0] ra1;

    valid_pipeline_ctrl #(.ROWS(4), .COLS(4), .LOAD_LEN(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .mode(mode0), .start(start0), .busy(busy0),
        .w_shift_en(wsh0), .w_latch(wl0), .in_valid(iv0), .rd_addr(ra0),
        .done(done0)
    );

    valid_pipeline_ctrl #(.ROWS(2), .COLS(1), .LOAD_LEN(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .mode(mode1), .start(start1), .busy(busy1),
        .w_shift_en(wsh1), .w_latch(wl1), .in_valid(iv1), .rd_addr(ra1),
        .done(done1)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [15:0] v;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_pass   = 0;
    int timeouts_req  = 0;
    int timeouts_seen = 0;

    // Expected outputs k cycles after start was sampled, from the run timeline.
    function automatic logic [15:0] model(input int k, input int R,
                                          input int N, input int C);
        int   L;
        int   T;
        int   t;
        logic stream;
        logic [3:0] iv;
        logic [7:0] ra;
        L = R + (N + R - 1) + C;
        T = N + R - 1;
        t = k - R - 1;
        stream = (t >= 0) && (t < T);
        iv = 4'b0;
        for (int r = 0; r < R; r++) iv[r] = stream && (r <= t) && (t < r + N);
        ra = 8'd0;
        if (stream) ra = (t < N) ? 8'(t) : 8'(N - 1);
        return {(k >= 1) && (k <= L), (k >= 1) && (k <= R), stream && (t == 0),
                iv, ra, (k == L + 1)};
    endfunction

    task automatic push_exp(input int dut, input int unsigned c, input logic [15:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        if (dut == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    // Run started in cycle s; cycles at or after kstop are expected all-zero.
    task automatic push_run(input int dut, input int unsigned s, input int R,
                            input int N, input int C, input int kstop);
        int L;
        L = R + (N + R - 1) + C;
        for (int k = 1; k <= L + 2; k++)
            push_exp(dut, s + k, (k < kstop) ? model(k, R, N, C) : 16'h0);
    endtask

    task automatic push_zero(input int dut, input int unsigned from_c,
                             input int unsigned to_c);
        for (int unsigned c = from_c; c <= to_c; c++) push_exp(dut, c, 16'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse0(input logic [2:0] m);
        mode0  = m;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        mode0  = MODE_IDLE;
    endtask

    task automatic pulse1(input logic [2:0] m);
        mode1  = m;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        mode1  = MODE_IDLE;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) timeouts_req++;
    endtask

    // Monitor / scoreboard
    exp_t        e0, e1;
    logic [15:0] act0, act1;
    always @(negedge clk) begin
        act0 = {busy0, wsh0, wl0, iv0, ra0, done0};
        act1 = {busy1, wsh1, wl1, 2'b00, iv1, ra1, done1};
        if (q0.size() > 0 && q0[0].cyc <= cyc) begin
            e0 = q0.pop_front();
            n_checks++;
            if (act0 === e0.v) n_pass++;
            else $display("FAIL dut0_outputs cycle=%0d exp_cycle=%0d act=%h exp=%h",
                          cyc, e0.cyc, act0, e0.v);
        end
        if (q1.size() > 0 && q1[0].cyc <= cyc) begin
            e1 = q1.pop_front();
            n_checks++;
            if (act1 === e1.v) n_pass++;
            else $display("FAIL dut1_outputs cycle=%0d exp_cycle=%0d act=%h exp=%h",
                          cyc, e1.cyc, act1, e1.v);
        end
        if (timeouts_req != timeouts_seen) begin
            timeouts_seen++;
            n_checks++;
            $display("FAIL wait_bound cycle=%0d act=expired req=event_within_bound", cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout act=time_exhausted req=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned s;
        int          n;
        logic        seen;

        // Reset state
        push_zero(0, 1, 3);
        push_zero(1, 1, 3);
        tick(); tick(); tick();
        rst = 1'b0;
        tick();

        // Basic run with defaults
        s = cyc;
        $display("run basic start_cycle=%0d", s);
        push_run(0, s, 4, 4, 4, 1000);
        pulse0(MODE_LOAD);
        wait_drain(40);

        // Starts with non-LOAD modes are ignored
        s = cyc;
        $display("run ignored_mode2 start_cycle=%0d", s);
        push_zero(0, s + 1, s + 20);
        pulse0(MODE_LAYER);
        wait_drain(40);

        s = cyc;
        $display("run ignored_mode0 start_cycle=%0d", s);
        push_zero(0, s + 1, s + 20);
        pulse0(MODE_IDLE);
        wait_drain(40);

        // Extra starts at cycle 7 (busy) and cycle 16 (S_DONE) are ignored
        s = cyc;
        $display("run stray_starts start_cycle=%0d", s);
        push_run(0, s, 4, 4, 4, 1000);
        push_zero(0, s + 18, s + 20);
        pulse0(MODE_LOAD);
        while (cyc < s + 7) tick();
        pulse0(MODE_LOAD);
        while (cyc < s + 16) tick();
        pulse0(MODE_LOAD);
        wait_drain(40);

        // Asynchronous reset mid-run at cycle 9 for 2 cycles
        s = cyc;
        $display("run mid_reset start_cycle=%0d", s);
        push_run(0, s, 4, 4, 4, 9);
        push_zero(0, s + 18, s + 22);
        pulse0(MODE_LOAD);
        while (cyc < s + 9) tick();
        #2;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wait_drain(40);

        // Fresh run after the reset
        s = cyc;
        $display("run after_reset start_cycle=%0d", s);
        push_run(0, s, 4, 4, 4, 1000);
        pulse0(MODE_LOAD);
        wait_drain(40);

        // Back-to-back runs: sequencer restarts the cycle after it sees busy low
        for (int i = 0; i < 3; i++) begin
            s = cyc;
            $display("run back_to_back_%0d start_cycle=%0d", i, s);
            push_run(0, s, 4, 4, 4, 1000);
            pulse0(MODE_LOAD);
            seen = 1'b0;
            n = 0;
            while (n < 40) begin
                if (busy0) seen = 1'b1;
                else if (seen) break;
                tick();
                n++;
            end
            if (n >= 40) timeouts_req++;
            tick();
        end
        wait_drain(40);

        // Small configuration: ROWS=2, LOAD_LEN=1, COLS=1
        s = cyc;
        $display("run small_cfg start_cycle=%0d", s);
        push_run(1, s, 2, 1, 1, 1000);
        push_zero(1, s + 8, s + 10);
        pulse1(MODE_LOAD);
        wait_drain(40);

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_valid_pipeline_ctrl
